// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle between the data-memory sequencer, its two requesters and the word-wide memory.
// The slave modport is the controller's view; master is everything around it.
interface dmem_access_ctrl_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  core_req;
   logic                  core_we;
   logic [31:0]           core_addr;
   logic [1:0]            core_size;
   logic                  core_unsigned;
   logic [31:0]           core_wdata;
   logic                  core_ready;
   logic [31:0]           core_rdata;
   logic                  core_err;
   logic                  dbg_req;
   logic                  dbg_we;
   logic [ADDR_WIDTH-1:0] dbg_addr;
   logic [31:0]           dbg_wdata;
   logic                  dbg_ready;
   logic [31:0]           dbg_rdata;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;

   // Handshake: a requester raises req with stable fields and holds them until its
   // ready pulses for one cycle; req still high in the following cycle is a new request.
   modport slave (
      input  core_req, core_we, core_addr, core_size, core_unsigned, core_wdata,
      output core_ready, core_rdata, core_err,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_ready, dbg_rdata,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output core_req, core_we, core_addr, core_size, core_unsigned, core_wdata,
      input  core_ready, core_rdata, core_err,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_ready, dbg_rdata,
      input  mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Round-robin sequencer sharing a word-wide data memory between the core and a debug port.
// Sub-word stores are read-modify-write; loads are lane-selected and extended.
module dmem_access_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   dmem_access_ctrl_if.slave   bus,
   output logic [1:0]          fsm_state
);
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] ACCESS   = 2'd1;
   localparam logic [1:0] MERGE_WR = 2'd2;
   localparam logic [1:0] DONE     = 2'd3;

   logic [1:0]            state;
   logic                  last_dbg;
   logic                  gnt_dbg;
   logic                  op_we;
   logic [1:0]            op_size;
   logic                  op_uns;
   logic [1:0]            op_lane;
   logic                  op_err;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [DATA_WIDTH-1:0] core_rdata_q;
   logic [DATA_WIDTH-1:0] dbg_rdata_q;

   logic                  dec_err;
   logic                  pick_dbg;
   logic                  partial_store;
   logic                  full_store;
   logic [7:0]            lane_b;
   logic [15:0]           lane_h;
   logic [DATA_WIDTH-1:0] load_ext;
   logic [DATA_WIDTH-1:0] merged;

   always_comb begin
      dec_err = (bus.core_size == 2'b11)
             || (bus.core_size == 2'b01 && bus.core_addr[0])
             || (bus.core_size == 2'b10 && bus.core_addr[1:0] != 2'b00)
             || (|bus.core_addr[31:ADDR_WIDTH+2]);
      // last_dbg = 1 means the debug port won last time, so the core wins a tie.
      pick_dbg      = bus.dbg_req && (!bus.core_req || !last_dbg);
      partial_store = op_we && !op_err && (op_size != 2'b10);
      full_store    = op_we && !op_err && (op_size == 2'b10);
   end

   always_comb begin
      case (op_lane)
         2'd0:    lane_b = bus.mem_rdata[7:0];
         2'd1:    lane_b = bus.mem_rdata[15:8];
         2'd2:    lane_b = bus.mem_rdata[23:16];
         default: lane_b = bus.mem_rdata[31:24];
      endcase
      lane_h = op_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (op_size)
         2'b00:   load_ext = {{24{!op_uns && lane_b[7]}}, lane_b};
         2'b01:   load_ext = {{16{!op_uns && lane_h[15]}}, lane_h};
         default: load_ext = bus.mem_rdata;
      endcase
   end

   // mem_wdata_q still holds the right-aligned store data while in ACCESS.
   always_comb begin
      merged = bus.mem_rdata;
      if (op_size == 2'b00) begin
         case (op_lane)
            2'd0:    merged[7:0]   = mem_wdata_q[7:0];
            2'd1:    merged[15:8]  = mem_wdata_q[7:0];
            2'd2:    merged[23:16] = mem_wdata_q[7:0];
            default: merged[31:24] = mem_wdata_q[7:0];
         endcase
      end else if (op_lane[1]) begin
         merged[31:16] = mem_wdata_q[15:0];
      end else begin
         merged[15:0] = mem_wdata_q[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         last_dbg     <= 1'b1;
         gnt_dbg      <= 1'b0;
         op_we        <= 1'b0;
         op_size      <= 2'b00;
         op_uns       <= 1'b0;
         op_lane      <= 2'b00;
         op_err       <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         core_rdata_q <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.core_req || bus.dbg_req) begin
                  state    <= ACCESS;
                  gnt_dbg  <= pick_dbg;
                  last_dbg <= pick_dbg;
                  if (pick_dbg) begin
                     op_we       <= bus.dbg_we;
                     op_size     <= 2'b10;
                     op_uns      <= 1'b0;
                     op_lane     <= 2'b00;
                     op_err      <= 1'b0;
                     mem_addr_q  <= bus.dbg_addr;
                     mem_wdata_q <= bus.dbg_wdata;
                  end else begin
                     op_we   <= bus.core_we;
                     op_size <= bus.core_size;
                     op_uns  <= bus.core_unsigned;
                     op_lane <= bus.core_addr[1:0];
                     op_err  <= dec_err;
                     if (!dec_err) begin
                        mem_addr_q  <= bus.core_addr[ADDR_WIDTH+1:2];
                        mem_wdata_q <= bus.core_wdata;
                     end
                  end
               end
            end
            // A rejected access idles through ACCESS so every non-merge response
            // arrives with the same latency; memory is never written for it.
            ACCESS: begin
               state <= partial_store ? MERGE_WR : DONE;
               if (!op_err && !op_we) begin
                  if (gnt_dbg) dbg_rdata_q  <= bus.mem_rdata;
                  else         core_rdata_q <= load_ext;
               end
               if (partial_store) mem_wdata_q <= merged;
            end
            MERGE_WR: state <= DONE;
            default:  state <= IDLE;
         endcase
      end
   end

   assign fsm_state      = state;
   assign bus.mem_we     = ((state == ACCESS) && full_store) || (state == MERGE_WR);
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.core_ready = (state == DONE) && !gnt_dbg;
   assign bus.core_err   = (state == DONE) && !gnt_dbg && op_err;
   assign bus.core_rdata = core_rdata_q;
   assign bus.dbg_ready  = (state == DONE) && gnt_dbg;
   assign bus.dbg_rdata  = dbg_rdata_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, contention and reset sequences,
// then random core/debug traffic against a byte-addressed reference memory.
module tb_dmem_access_ctrl;
   localparam int AW = 10;
   localparam int NBYTES = 4 << AW;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  fsm_state;
   logic [31:0] mem [0:(1<<AW)-1];
   logic [7:0]  ref_b [0:NBYTES-1];
   int          we_count = 0;
   logic [AW-1:0] last_waddr = '0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic        exp_q [$];

   dmem_access_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   dmem_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .fsm_state (fsm_state)
   );

   // ---------------- clock / memory model ----------------
   always #5 clk = ~clk;

   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
         we_count          <= we_count + 1;
         last_waddr        <= bus.mem_addr;
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input int byte_addr);
      return {ref_b[byte_addr+3], ref_b[byte_addr+2], ref_b[byte_addr+1], ref_b[byte_addr]};
   endfunction

   // Reference: byte-addressed memory, alignment/range rules, fixed latencies.
   task automatic ref_core(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata,
                           output logic err, output logic [31:0] rd, output int lat, output int wes);
      int n;
      logic [31:0] v;
      n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      err = (size == 2'b11) || (addr % n != 0) || (addr >= NBYTES);
      rd  = 32'h0;
      lat = 2;
      wes = 0;
      if (!err && we) begin
         for (int i = 0; i < n; i++) ref_b[addr+i] = 8'((wdata >> (8*i)) & 32'hFF);
         lat = (n == 4) ? 2 : 3;
         wes = 1;
      end else if (!err) begin
         v = 32'h0;
         for (int i = 0; i < n; i++) v = v | (32'(ref_b[addr+i]) << (8*i));
         if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
         rd = v;
      end
   endtask

   // ---------------- drivers ----------------
   task automatic do_core(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rd, output logic err, output int wes);
      int base;
      bit done;
      @(negedge clk);
      bus.core_we = we; bus.core_addr = addr; bus.core_size = size;
      bus.core_unsigned = uns; bus.core_wdata = wdata; bus.core_req = 1'b1;
      base = we_count; lat = 0; done = 0; rd = 'x; err = 1'bx;
      while (!done && lat < 20) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (bus.core_ready) begin
            done = 1; rd = bus.core_rdata; err = bus.core_err;
         end
      end
      bus.core_req = 1'b0;
      wes = we_count - base;
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL core_timeout actual=no_ready expected=ready addr=%h", addr);
      end
   endtask

   task automatic do_dbg(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rd, output int wes);
      int base;
      bit done;
      @(negedge clk);
      bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata; bus.dbg_req = 1'b1;
      base = we_count; lat = 0; done = 0; rd = 'x;
      while (!done && lat < 20) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (bus.dbg_ready) begin
            done = 1; rd = bus.dbg_rdata;
         end
      end
      bus.dbg_req = 1'b0;
      wes = we_count - base;
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL dbg_timeout actual=no_ready expected=ready addr=%h", addr);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs [15];

   initial begin
      int lat, wes, e_lat, e_wes, grants, cyc, ready_seen, base;
      logic [31:0] rd, e_rd, w;
      logic err, e_err, got;

      vecs[0]  = '{1'b1, 32'h100,  2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 2};
      vecs[1]  = '{1'b0, 32'h100,  2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 2};
      vecs[2]  = '{1'b1, 32'h101,  2'b00, 1'b0, 32'h000000AA, 32'h0,        1'b0, 3};
      vecs[3]  = '{1'b0, 32'h100,  2'b10, 1'b0, 32'h0,        32'hDEADAAEF, 1'b0, 2};
      vecs[4]  = '{1'b0, 32'h101,  2'b00, 1'b0, 32'h0,        32'hFFFFFFAA, 1'b0, 2};
      vecs[5]  = '{1'b0, 32'h101,  2'b00, 1'b1, 32'h0,        32'h000000AA, 1'b0, 2};
      vecs[6]  = '{1'b1, 32'h102,  2'b01, 1'b0, 32'h00001234, 32'h0,        1'b0, 3};
      vecs[7]  = '{1'b0, 32'h102,  2'b01, 1'b0, 32'h0,        32'h00001234, 1'b0, 2};
      vecs[8]  = '{1'b0, 32'h100,  2'b10, 1'b0, 32'h0,        32'h1234AAEF, 1'b0, 2};
      vecs[9]  = '{1'b0, 32'h102,  2'b10, 1'b0, 32'h0,        32'h0,        1'b1, 2};
      vecs[10] = '{1'b1, 32'h103,  2'b01, 1'b0, 32'h0000FFFF, 32'h0,        1'b1, 2};
      vecs[11] = '{1'b0, 32'h1000, 2'b10, 1'b0, 32'h0,        32'h0,        1'b1, 2};
      vecs[12] = '{1'b1, 32'h100,  2'b11, 1'b0, 32'h55555555, 32'h0,        1'b1, 2};
      vecs[13] = '{1'b1, 32'hFFF,  2'b00, 1'b0, 32'h0000005A, 32'h0,        1'b0, 3};
      vecs[14] = '{1'b0, 32'hFFE,  2'b01, 1'b0, 32'h0,        32'h00005A00, 1'b0, 2};

      for (int i = 0; i < (1 << AW); i++) begin
         w = $urandom;
         mem[i] = w;
         for (int b = 0; b < 4; b++) ref_b[4*i+b] = 8'((w >> (8*b)) & 32'hFF);
      end
      // 0xFFE/0xFFF half is made known so the upper-boundary half load is predictable.
      mem[(1<<AW)-1][31:16] = 16'h0000;
      ref_b[NBYTES-2] = 8'h00;
      ref_b[NBYTES-1] = 8'h00;

      // ---- reset with random inputs ----
      for (int k = 0; k < 4; k++) begin
         bus.core_req = 1'($urandom); bus.core_we = 1'($urandom); bus.core_addr = $urandom;
         bus.core_size = 2'($urandom); bus.core_unsigned = 1'($urandom); bus.core_wdata = $urandom;
         bus.dbg_req = 1'($urandom); bus.dbg_we = 1'($urandom); bus.dbg_addr = AW'($urandom);
         bus.dbg_wdata = $urandom;
         @(posedge clk); #1;
         check("rst_strobes", {28'h0, bus.core_ready, bus.dbg_ready, bus.core_err, bus.mem_we}, 32'h0);
         check("rst_core_rdata", bus.core_rdata, 32'h0);
         check("rst_dbg_rdata", bus.dbg_rdata, 32'h0);
         check("rst_mem_bus", {bus.mem_wdata[21:0], bus.mem_addr}, 32'h0);
      end
      @(negedge clk);
      bus.core_req = 1'b0; bus.dbg_req = 1'b0;
      rst_n = 1'b1;
      base = we_count;
      repeat (20) @(posedge clk);
      check("idle_no_write", 32'(we_count - base), 32'h0);

      // ---- continuous contention: strict alternation starting with core ----
      @(negedge clk);
      bus.core_we = 1'b0; bus.core_addr = 32'h100; bus.core_size = 2'b10; bus.core_unsigned = 1'b0;
      bus.dbg_we = 1'b0; bus.dbg_addr = AW'(10'h41);
      bus.core_req = 1'b1; bus.dbg_req = 1'b1;
      for (int k = 0; k < 8; k++) exp_q.push_back(1'(k % 2));
      grants = 0; cyc = 0;
      while (grants < 8 && cyc < 200) begin
         @(posedge clk); cyc++;
         @(negedge clk);
         if (bus.core_ready || bus.dbg_ready) begin
            got = bus.dbg_ready;
            check("arb_order", {31'h0, got}, {31'h0, exp_q.pop_front()});
            if (got) check("arb_dbg_rdata", bus.dbg_rdata, ref_word(32'h104));
            else     check("arb_core_rdata", bus.core_rdata, ref_word(32'h100));
            grants++;
         end
      end
      bus.core_req = 1'b0; bus.dbg_req = 1'b0;
      check("arb_grants", 32'(grants), 32'd8);

      // ---- directed table ----
      foreach (vecs[i]) begin
         do_core(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, lat, rd, err, wes);
         ref_core(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, e_err, e_rd, e_lat, e_wes);
         check($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vecs[i].err});
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("vec%0d_wes", i), 32'(wes), (vecs[i].we && !vecs[i].err) ? 32'd1 : 32'd0);
         if (!vecs[i].we && !vecs[i].err) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
         if (vecs[i].we && !vecs[i].err)
            check($sformatf("vec%0d_waddr", i), {22'h0, last_waddr}, {22'h0, vecs[i].addr[AW+1:2]});
      end
      check("err_mem_unchanged", mem[10'h40], 32'h1234AAEF);

      // ---- debug port word store and load ----
      do_dbg(1'b1, AW'(10'h55), 32'hCAFEF00D, lat, rd, wes);
      for (int b = 0; b < 4; b++) ref_b[32'h154+b] = 8'((32'hCAFEF00D >> (8*b)) & 32'hFF);
      check("dbg_sw_lat", 32'(lat), 32'd2);
      check("dbg_sw_wes", 32'(wes), 32'd1);
      do_dbg(1'b0, AW'(10'h55), 32'h0, lat, rd, wes);
      check("dbg_lw_rdata", rd, 32'hCAFEF00D);
      check("dbg_lw_wes", 32'(wes), 32'd0);

      // ---- reset during ACCESS of a byte store ----
      @(negedge clk);
      bus.core_we = 1'b1; bus.core_addr = 32'h200; bus.core_size = 2'b00;
      bus.core_unsigned = 1'b0; bus.core_wdata = 32'h77; bus.core_req = 1'b1;
      base = we_count; ready_seen = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_mem_we", {31'h0, bus.mem_we}, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus.core_ready) ready_seen++;
      end
      bus.core_req = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_no_ready", 32'(ready_seen), 32'd0);
      check("midrst_no_write", 32'(we_count - base), 32'd0);
      check("midrst_word_kept", mem[10'h80], ref_word(32'h200));
      do_core(1'b0, 32'h200, 2'b10, 1'b0, 32'h0, lat, rd, err, wes);
      check("postrst_rdata", rd, ref_word(32'h200));
      check("postrst_lat", 32'(lat), 32'd2);

      // ---- random traffic against the reference ----
      for (int k = 0; k < 60; k++) begin
         logic        r_we, r_uns;
         logic [31:0] r_addr, r_wdata;
         logic [1:0]  r_size;
         logic [AW-1:0] d_addr;
         if ($urandom_range(0, 3) == 0) begin
            r_we = 1'($urandom); d_addr = AW'($urandom_range(32'h40, 32'h4F)); r_wdata = $urandom;
            e_rd = ref_word(4 * int'(d_addr));
            do_dbg(r_we, d_addr, r_wdata, lat, rd, wes);
            if (r_we) for (int b = 0; b < 4; b++) ref_b[4*d_addr+b] = 8'((r_wdata >> (8*b)) & 32'hFF);
            else check($sformatf("rnd%0d_dbg_rdata", k), rd, e_rd);
            check($sformatf("rnd%0d_dbg_wes", k), 32'(wes), {31'h0, r_we});
         end else begin
            r_we = 1'($urandom); r_uns = 1'($urandom); r_size = 2'($urandom_range(0, 3));
            r_wdata = $urandom;
            r_addr = $urandom_range(32'h100, 32'h13F);
            if ($urandom_range(0, 7) == 0) r_addr = r_addr | (32'd1 << $urandom_range(12, 31));
            do_core(r_we, r_addr, r_size, r_uns, r_wdata, lat, rd, err, wes);
            ref_core(r_we, r_addr, r_size, r_uns, r_wdata, e_err, e_rd, e_lat, e_wes);
            check($sformatf("rnd%0d_err", k), {31'h0, err}, {31'h0, e_err});
            check($sformatf("rnd%0d_lat", k), 32'(lat), 32'(e_lat));
            check($sformatf("rnd%0d_wes", k), 32'(wes), 32'(e_wes));
            if (!r_we && !e_err) check($sformatf("rnd%0d_rdata", k), rd, e_rd);
         end
      end
      for (int i = 32'h40; i < 32'h50; i++)
         check($sformatf("final_word_%0h", i), mem[i], ref_word(4 * i));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
